absorb_fsm: RTL and testbench
=============================

ABSORB_FSM -- requirements
Module: absorb_fsm

Interface
REQ-001 clk  in  1  system clock, all state on rising edge.
REQ-002 rst  in  1  reset, asynchronous, active-high.
REQ-003 mode  in  1  0 = SHAKE128 (rate 21 words), 1 = SHAKE256 (rate 17 words); sampled on first accepted word of a message.
REQ-004 data_in  in  64  message word, little-endian bytes (byte 0 = bits 7:0).
REQ-005 valid_in  in  1  data_in valid.
REQ-006 last_in  in  1  data_in is final message word.
REQ-007 last_bytes  in  3  valid bytes in final word; 0 encodes 8.
REQ-008 ready_out  out  1  block accepts a word this cycle.
REQ-009 buf_we  out  1  write buf_data to input buffer slot buf_idx.
REQ-010 buf_data  out  64  data or padding word to buffer.
REQ-011 buf_idx  out  5  word slot within current block, 0..rate-1.
REQ-012 block_valid  out  1  full rate block resident in buffer, permutation may absorb.
REQ-013 block_ack  in  1  permutation has consumed the block; buffer free.
REQ-014 last_block  out  1  qualifies block_valid: final (padded) block of message.

Function
REQ-015 States SHALL be IDLE, ABSORB, PAD_WORD, ZERO_FILL, BLOCK_WAIT.
REQ-016 Word transfer SHALL occur iff valid_in && ready_out; buf_we, buf_data, buf_idx SHALL be combinational in that cycle (zero latency).
REQ-017 ready_out SHALL be 1 in IDLE and ABSORB, 0 in all other states.
REQ-018 IDLE: on transfer, latch rate from mode, write slot 0, go ABSORB (or per REQ-020/021 if last_in).
REQ-019 ABSORB, non-last transfer: write slot idx, idx+1; at idx = rate-1 go BLOCK_WAIT with last_block=0.
REQ-020 Last transfer, last_bytes 1..7: bytes >= last_bytes SHALL be zeroed, byte[last_bytes] = 0x1F; if idx = rate-1 byte 7 |= 0x80 and go BLOCK_WAIT with last_block=1; else go ZERO_FILL.
REQ-021 Last transfer, full word (last_bytes=0): write word unmodified, set pad_pending; if idx = rate-1 go BLOCK_WAIT with last_block=0, else go PAD_WORD.
REQ-022 PAD_WORD: write 0x000000000000001F at idx (0x800000000000001F if idx = rate-1, then BLOCK_WAIT last_block=1), clear pad_pending, else go ZERO_FILL.
REQ-023 ZERO_FILL: write 0 each cycle; at idx = rate-1 write 0x8000000000000000 and go BLOCK_WAIT with last_block=1.
REQ-024 BLOCK_WAIT: block_valid=1, no writes; on block_ack reset idx to 0 and go PAD_WORD if pad_pending, IDLE if last_block, else ABSORB.
REQ-025 block_ack outside BLOCK_WAIT SHALL be ignored; valid_in when ready_out=0 SHALL not be consumed.
REQ-026 idx SHALL never exceed rate-1; mode changes mid-message SHALL have no effect.

Reset
REQ-027 On rst: state IDLE, idx 0, pad_pending 0, last_block 0, latched rate 21; hence ready_out=1, buf_we=0, block_valid=0, buf_data=0.
REQ-028 rst mid-message SHALL abandon the message with no further buf_we or block_valid.

Structure
REQ-029 shake_pkg SHALL hold RATE_WORDS_128=21, RATE_WORDS_256=17, PAD_DS=0x1F, PAD_END=0x80 and the absorb state enum.
REQ-030 Byte masking/padding insertion SHALL be a combinational sub-module absorb_pad_gen (inputs word, last_bytes, is_last, is_final_slot).

Verification
REQ-031 mode=0, 1-word message 0x..AABB, last_bytes=2 -> slot0 = 0x00001FAABB..., slots 1..19 = 0, slot20 = 0x8000000000000000, block_valid & last_block.
REQ-032 mode=1, 17 full words, last on word 17 -> block 1 last_block=0; after block_ack block 2: slot0 = 0x1F, slot16 = 0x80<<56, last_block=1.
REQ-033 mode=1, 16 full words last on 16th -> slot16 = 0x800000000000001F, single block, last_block=1.
REQ-034 mode=0, last word at slot 20, last_bytes=7 -> slot20 byte7 = 0x9F, no ZERO_FILL cycles.
REQ-035 valid_in held high through BLOCK_WAIT, block_ack delayed 5 cycles -> ready_out=0, no words lost or duplicated, idx restarts at 0.
REQ-036 rst asserted in ZERO_FILL at idx 10 -> next cycle IDLE, ready_out=1, no block_valid; following message absorbed correctly.

Source files
------------

// File: rtl/shake_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : shake_pkg
//  Description : Shared SHAKE absorb constants, state encoding and helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package shake_pkg;

    localparam int         RATE_WORDS_128 = 21;
    localparam int         RATE_WORDS_256 = 17;
    localparam logic [7:0] PAD_DS         = 8'h1F;
    localparam logic [7:0] PAD_END        = 8'h80;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ABSORB     = 3'd1,
        ST_PAD_WORD   = 3'd2,
        ST_ZERO_FILL  = 3'd3,
        ST_BLOCK_WAIT = 3'd4
    } absorb_state_t;

    function automatic logic [4:0] rate_of(input logic mode);
        return mode ? 5'(RATE_WORDS_256) : 5'(RATE_WORDS_128);
    endfunction

endpackage
`default_nettype wire

// File: rtl/absorb_pad_gen.sv
`default_nettype none
// ============================================================================
//  Module      : absorb_pad_gen
//  Description : Masks a partial final word and inserts the SHAKE padding.
//  Revision    : 1.0 - initial release
// ============================================================================
module absorb_pad_gen
    import shake_pkg::*;
(
    input  logic [63:0] word,
    input  logic [2:0]  last_bytes,
    input  logic        is_last,
    input  logic        is_final_slot,
    output logic [63:0] padded
);

    // A full final word (last_bytes == 0) passes through; its padding
    // follows in a separate word.
    always_comb begin
        padded = word;
        if (is_last && (last_bytes != 3'd0)) begin
            for (int b = 0; b < 8; b++) begin
                if (b > int'(last_bytes)) begin
                    padded[b*8 +: 8] = 8'h00;
                end else if (b == int'(last_bytes)) begin
                    padded[b*8 +: 8] = PAD_DS;
                end
            end
            if (is_final_slot) begin
                padded[63:56] = padded[63:56] | PAD_END;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/absorb_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : absorb_fsm
//  Description : SHAKE128/256 message absorb sequencer feeding a rate buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
module absorb_fsm
    import shake_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        mode,
    input  logic [63:0] data_in,
    input  logic        valid_in,
    input  logic        last_in,
    input  logic [2:0]  last_bytes,
    output logic        ready_out,
    output logic        buf_we,
    output logic [63:0] buf_data,
    output logic [4:0]  buf_idx,
    output logic        block_valid,
    input  logic        block_ack,
    output logic        last_block
);

    absorb_state_t r_state, w_state_nxt;
    logic [4:0]    r_idx, w_idx_nxt;
    logic [4:0]    r_rate, w_rate_nxt;
    logic          r_pad_pending, w_pad_nxt;
    logic          r_last_block, w_last_nxt;

    logic [4:0]    w_rate;
    logic          w_final;
    logic [63:0]   w_pad_word;

    // The first word of a message is judged against the rate it is about to latch.
    assign w_rate  = (r_state == ST_IDLE) ? rate_of(mode) : r_rate;
    assign w_final = (r_idx == (w_rate - 5'd1));

    absorb_pad_gen u_pad_gen (
        .word          (data_in),
        .last_bytes    (last_bytes),
        .is_last       (last_in),
        .is_final_slot (w_final),
        .padded        (w_pad_word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_idx         <= 5'd0;
            r_rate        <= 5'(RATE_WORDS_128);
            r_pad_pending <= 1'b0;
            r_last_block  <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_idx         <= w_idx_nxt;
            r_rate        <= w_rate_nxt;
            r_pad_pending <= w_pad_nxt;
            r_last_block  <= w_last_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_rate_nxt  = r_rate;
        w_pad_nxt   = r_pad_pending;
        w_last_nxt  = r_last_block;
        ready_out   = 1'b0;
        buf_we      = 1'b0;
        buf_data    = 64'd0;
        block_valid = 1'b0;

        case (r_state)
            ST_IDLE, ST_ABSORB: begin
                ready_out = 1'b1;
                if (valid_in) begin
                    buf_we   = 1'b1;
                    buf_data = w_pad_word;
                    if (r_state == ST_IDLE) begin
                        w_rate_nxt = w_rate;
                    end
                    if (w_final) begin
                        w_state_nxt = ST_BLOCK_WAIT;
                        w_last_nxt  = last_in && (last_bytes != 3'd0);
                        w_pad_nxt   = last_in && (last_bytes == 3'd0);
                    end else begin
                        w_idx_nxt = r_idx + 5'd1;
                        if (!last_in) begin
                            w_state_nxt = ST_ABSORB;
                        end else if (last_bytes != 3'd0) begin
                            w_state_nxt = ST_ZERO_FILL;
                        end else begin
                            w_pad_nxt   = 1'b1;
                            w_state_nxt = ST_PAD_WORD;
                        end
                    end
                end
            end

            ST_PAD_WORD: begin
                buf_we    = 1'b1;
                buf_data  = {56'd0, PAD_DS};
                w_pad_nxt = 1'b0;
                if (w_final) begin
                    buf_data[63:56] = PAD_END;
                    w_last_nxt      = 1'b1;
                    w_state_nxt     = ST_BLOCK_WAIT;
                end else begin
                    w_idx_nxt   = r_idx + 5'd1;
                    w_state_nxt = ST_ZERO_FILL;
                end
            end

            ST_ZERO_FILL: begin
                buf_we = 1'b1;
                if (w_final) begin
                    buf_data    = {PAD_END, 56'd0};
                    w_last_nxt  = 1'b1;
                    w_state_nxt = ST_BLOCK_WAIT;
                end else begin
                    w_idx_nxt = r_idx + 5'd1;
                end
            end

            ST_BLOCK_WAIT: begin
                block_valid = 1'b1;
                if (block_ack) begin
                    w_idx_nxt = 5'd0;
                    if (r_pad_pending) begin
                        w_state_nxt = ST_PAD_WORD;
                    end else if (r_last_block) begin
                        w_last_nxt  = 1'b0;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_ABSORB;
                    end
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_idx_nxt   = 5'd0;
            end
        endcase
    end

    assign buf_idx    = r_idx;
    assign last_block = (r_state == ST_BLOCK_WAIT) && r_last_block;

endmodule
`default_nettype wire

// File: tb/tb_absorb_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_absorb_fsm
//  Description : Self-checking bench for absorb_fsm against a byte-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_absorb_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic        mode;
    logic [63:0] data_in;
    logic        valid_in;
    logic        last_in;
    logic [2:0]  last_bytes;
    logic        ready_out;
    logic        buf_we;
    logic [63:0] buf_data;
    logic [4:0]  buf_idx;
    logic        block_valid;
    logic        block_ack;
    logic        last_block;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] msg [0:63];
    logic [63:0] exp_words [$];

    absorb_fsm dut (
        .clk         (clk),
        .rst         (rst),
        .mode        (mode),
        .data_in     (data_in),
        .valid_in    (valid_in),
        .last_in     (last_in),
        .last_bytes  (last_bytes),
        .ready_out   (ready_out),
        .buf_we      (buf_we),
        .buf_data    (buf_data),
        .buf_idx     (buf_idx),
        .block_valid (block_valid),
        .block_ack   (block_ack),
        .last_block  (last_block)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: raw message bytes, 0x1F, zeros to a rate multiple, 0x80 on the last byte.
    function automatic void build_expect(input logic md, input int n, input logic [2:0] lb);
        byte unsigned bq [$];
        int           rate;
        int           nb;
        logic [63:0]  x;
        rate = md ? 17 : 21;
        exp_words.delete();
        for (int i = 0; i < n; i++) begin
            nb = (i == n - 1 && lb != 3'd0) ? int'(lb) : 8;
            for (int b = 0; b < nb; b++) bq.push_back(msg[i][b*8 +: 8]);
        end
        bq.push_back(8'h1F);
        while (bq.size() % (rate * 8) != 0) bq.push_back(8'h00);
        bq[bq.size() - 1] = bq[bq.size() - 1] | 8'h80;
        for (int w = 0; w < bq.size() / 8; w++) begin
            for (int b = 0; b < 8; b++) x[b*8 +: 8] = bq[w*8 + b];
            exp_words.push_back(x);
        end
    endfunction

    task automatic do_reset();
        rst = 1'b1; valid_in = 1'b0; last_in = 1'b0; block_ack = 1'b0;
        mode = 1'b0; data_in = 64'd0; last_bytes = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", ready_out, 1);
        chk("rst_we", buf_we, 0);
        chk("rst_bvalid", block_valid, 0);
        chk("rst_data", buf_data, 0);
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    // Called just after a rising edge; returns just after a rising edge.
    task automatic run_msg(input logic md, input int n, input logic [2:0] lb,
                           input int ack_delay, input bit hold, input string tag);
        int rate, nblk, wi, blk, slot, wait_cnt, cyc;
        rate = md ? 17 : 21;
        build_expect(md, n, lb);
        nblk = exp_words.size() / rate;
        wi = 0; blk = 0; slot = 0; wait_cnt = 0; cyc = 0;
        while (blk < nblk && cyc < 3000) begin
            valid_in   = (wi < n) && (hold || ($urandom % 4 != 0));
            data_in    = (wi < n) ? msg[wi] : {$urandom, $urandom};
            last_in    = (wi == n - 1);
            last_bytes = last_in ? lb : 3'($urandom);
            mode       = (wi == 0) ? md : 1'($urandom);
            if (block_valid) block_ack = (wait_cnt >= ack_delay);
            else             block_ack = ($urandom % 6 == 0);
            @(negedge clk);
            if (buf_we) begin
                if (slot >= rate) begin
                    chk({tag, "_extra_write"}, buf_we, 0);
                end else begin
                    chk({tag, "_idx"}, buf_idx, 64'(slot));
                    chk({tag, "_data"}, buf_data, exp_words[blk*rate + slot]);
                    slot++;
                end
            end
            if (block_valid) begin
                chk({tag, "_ready_in_wait"}, ready_out, 0);
                if (wait_cnt == 0) begin
                    chk({tag, "_block_full"}, 64'(slot), 64'(rate));
                    chk({tag, "_last_block"}, last_block, (blk == nblk - 1));
                end
                if (block_ack) begin
                    blk++; slot = 0; wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end
            if (valid_in && ready_out) wi++;
            @(posedge clk); #1;
            cyc++;
        end
        if (cyc >= 3000) begin
            n_checks++; n_fail++;
            $display("FAIL %s_timeout: got %0d blocks required %0d", tag, blk, nblk);
        end
        valid_in = 1'b0; block_ack = 1'b0;
        @(negedge clk);
        chk({tag, "_words_used"}, 64'(wi), 64'(n));
        chk({tag, "_end_ready"}, ready_out, 1);
        chk({tag, "_end_bvalid"}, block_valid, 0);
        chk({tag, "_end_we"}, buf_we, 0);
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic        valid;
        logic        last;
        logic [2:0]  lb;
        logic [63:0] data;
        logic        exp_we;
        logic [63:0] exp_data;
    } vec_t;

    vec_t vt [7];
    bit   found;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        do_reset();

        // First-word padding at slot 0, probed combinationally without a clock edge.
        vt[0] = '{1'b0, 1'b0, 3'd0, 64'h1122334455667788, 1'b0, 64'h0};
        vt[1] = '{1'b1, 1'b0, 3'd0, 64'h0123456789ABCDEF, 1'b1, 64'h0123456789ABCDEF};
        vt[2] = '{1'b1, 1'b1, 3'd2, 64'h1122334455667788, 1'b1, 64'h00000000001F7788};
        vt[3] = '{1'b1, 1'b1, 3'd1, 64'h1122334455667788, 1'b1, 64'h0000000000001F88};
        vt[4] = '{1'b1, 1'b1, 3'd7, 64'h1122334455667788, 1'b1, 64'h1F22334455667788};
        vt[5] = '{1'b1, 1'b1, 3'd0, 64'h1122334455667788, 1'b1, 64'h1122334455667788};
        vt[6] = '{1'b1, 1'b1, 3'd3, 64'hFFFFFFFFFFFFFFFF, 1'b1, 64'h000000001FFFFFFF};
        for (int i = 0; i < 7; i++) begin
            mode = 1'b0; valid_in = vt[i].valid; last_in = vt[i].last;
            last_bytes = vt[i].lb; data_in = vt[i].data;
            #1;
            chk($sformatf("vec%0d_ready", i), ready_out, 1);
            chk($sformatf("vec%0d_we", i), buf_we, vt[i].exp_we);
            chk($sformatf("vec%0d_data", i), buf_data, vt[i].exp_data);
            chk($sformatf("vec%0d_idx", i), buf_idx, 0);
            valid_in = 1'b0;
            @(posedge clk); #1;
        end

        msg[0] = 64'h000000000000AABB;
        run_msg(1'b0, 1, 3'd2, 0, 1'b1, "one_word");

        for (int i = 0; i < 17; i++) msg[i] = {$urandom, $urandom};
        run_msg(1'b1, 17, 3'd0, 2, 1'b0, "full17");

        for (int i = 0; i < 16; i++) msg[i] = {$urandom, $urandom};
        run_msg(1'b1, 16, 3'd0, 1, 1'b1, "full16");

        for (int i = 0; i < 21; i++) msg[i] = {$urandom, $urandom};
        run_msg(1'b0, 21, 3'd7, 0, 1'b1, "slot20_lb7");

        for (int i = 0; i < 30; i++) msg[i] = {$urandom, $urandom};
        run_msg(1'b0, 30, 3'd5, 5, 1'b1, "hold_valid");

        // Reset while zero-filling must drop the message cleanly.
        mode = 1'b0; valid_in = 1'b1; last_in = 1'b1; last_bytes = 3'd3;
        data_in = {$urandom, $urandom}; block_ack = 1'b0;
        @(posedge clk); #1;
        valid_in = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk);
            if (buf_we && buf_idx == 5'd10) found = 1'b1;
        end
        chk("zf_reached_idx10", found, 1);
        rst = 1'b1;
        #1;
        chk("zf_rst_ready", ready_out, 1);
        chk("zf_rst_we", buf_we, 0);
        chk("zf_rst_bvalid", block_valid, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("zf_after_we", buf_we, 0);
            chk("zf_after_bvalid", block_valid, 0);
        end
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) msg[i] = {$urandom, $urandom};
        run_msg(1'b1, 3, 3'd4, 1, 1'b0, "post_rst");

        for (int t = 0; t < 30; t++) begin
            int n;
            n = 1 + int'($urandom % 45);
            for (int i = 0; i < n; i++) msg[i] = {$urandom, $urandom};
            run_msg(1'($urandom), n, 3'($urandom), int'($urandom % 5),
                    1'($urandom), $sformatf("rnd%0d", t));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
